// File: rtl/tone_scheduler.sv
// Melody sequencer and key/melody arbiter feeding the square-wave tone generator.
// Optional NOTE_GAP_EN: silences the tail of each melody note so repeated notes separate.
module tone_scheduler #(
    parameter int unsigned BEAT_DIV = 25000000,
    parameter int unsigned ROM_AW   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_en,
    input  logic              key_valid,
    input  logic [21:0]       key_div,
    input  logic              vol_up,
    input  logic              vol_down,
    input  logic              mute,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [21:0]       rom_div,
    input  logic [3:0]        rom_len,
    output logic [21:0]       note_div,
    output logic [15:0]       pos_vol,
    output logic [15:0]       neg_vol,
    output logic [1:0]        src,
    output logic [2:0]        vol_level,
    output logic              beat
);

    localparam int unsigned CW       = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int unsigned VOL_MAX  = 5;
    localparam logic [1:0]  SRC_NONE = 2'b00;
    localparam logic [1:0]  SRC_MEL  = 2'b01;
    localparam logic [1:0]  SRC_KEY  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_beats_left;
    logic [21:0]       r_mel_div;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [2:0]        r_vol;
    logic [21:0]       r_note_div;
    logic [15:0]       r_pos_vol;
    logic [15:0]       r_neg_vol;
    logic [1:0]        r_src;
    logic              r_beat;

    logic              w_run;
    logic              w_wrap;
    logic              w_note_end;
    logic              w_load;
    logic              w_eos;
    logic              w_gap;
    logic              w_mel_act;
    logic [1:0]        w_src;
    logic [21:0]       w_div;
    logic [15:0]       w_amp;

    function automatic logic [15:0] amp_of(input logic [2:0] lvl);
        case (lvl)
            3'd1:    amp_of = 16'h0800;
            3'd2:    amp_of = 16'h1000;
            3'd3:    amp_of = 16'h2000;
            3'd4:    amp_of = 16'h3000;
            3'd5:    amp_of = 16'h4000;
            default: amp_of = 16'h0000;
        endcase
    endfunction

    // A held key or a dropped play_en freezes every piece of melody state.
    assign w_run = play_en & ~key_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-cycle melody control strobes.
    always_comb begin
        w_next     = r_state;
        w_wrap     = 1'b0;
        w_note_end = 1'b0;
        w_load     = 1'b0;
        w_eos      = 1'b0;
        if (w_run) begin
            case (r_state)
                S_IDLE:  w_next = S_FETCH;
                S_FETCH: w_next = S_LOAD;
                S_LOAD: begin
                    w_next = (rom_len == 4'd0) ? S_FETCH : S_PLAY;
                    w_eos  = (rom_len == 4'd0);
                    w_load = (rom_len != 4'd0);
                end
                S_PLAY: begin
                    if (r_cnt == CW'(BEAT_DIV - 1)) begin
                        w_wrap = 1'b1;
                        if (r_beats_left == 4'd1) begin
                            w_note_end = 1'b1;
                            w_next     = S_FETCH;
                        end
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

`ifdef NOTE_GAP_EN
    localparam int unsigned GAP       = BEAT_DIV / 8;
    localparam int unsigned GAP_START = (GAP > 0) ? (BEAT_DIV - 1 - GAP) : 0;
    // Output is registered, so the window opens one count early; it stays shut through FETCH/LOAD.
    always_comb begin
        w_gap = 1'b0;
        if (GAP > 0) begin
            w_gap = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                    ((r_state == S_PLAY) && (r_beats_left == 4'd1) &&
                     (r_cnt >= CW'(GAP_START)));
        end
    end
`else
    assign w_gap = 1'b0;
`endif

    // Arbitration: key beats melody beats silence; silence keeps the last divider.
    always_comb begin
        w_mel_act = (r_state != S_IDLE) && play_en && (r_mel_div != 22'd0);
        w_src     = SRC_NONE;
        w_div     = r_note_div;
        w_amp     = amp_of(r_vol);
        if (key_valid) begin
            w_src = SRC_KEY;
            w_div = key_div;
        end else if (w_mel_act) begin
            w_src = SRC_MEL;
            w_div = r_mel_div;
            if (w_gap) w_amp = 16'h0000;
        end
        if ((w_src == SRC_NONE) || mute) w_amp = 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_beats_left <= 4'd0;
            r_mel_div    <= 22'd0;
            r_rom_addr   <= '0;
            r_vol        <= 3'd3;
            r_note_div   <= 22'd0;
            r_pos_vol    <= 16'h0000;
            r_neg_vol    <= 16'h0000;
            r_src        <= SRC_NONE;
            r_beat       <= 1'b0;
        end else begin
            r_beat <= w_wrap;
            if (w_load) begin
                r_mel_div    <= rom_div;
                r_beats_left <= rom_len;
                r_cnt        <= '0;
            end
            if (w_eos) r_rom_addr <= '0;
            if (w_run && (r_state == S_PLAY)) begin
                if (w_wrap) begin
                    r_cnt        <= '0;
                    r_beats_left <= r_beats_left - 4'd1;
                    if (w_note_end) r_rom_addr <= r_rom_addr + ROM_AW'(1);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            case ({vol_up, vol_down})
                2'b10:   if (r_vol < 3'(VOL_MAX)) r_vol <= r_vol + 3'd1;
                2'b01:   if (r_vol > 3'd0)        r_vol <= r_vol - 3'd1;
                default: r_vol <= r_vol;
            endcase
            r_note_div <= w_div;
            r_src      <= w_src;
            r_pos_vol  <= w_amp;
            r_neg_vol  <= 16'(~w_amp + 16'd1);
        end
    end

    assign rom_addr  = r_rom_addr;
    assign note_div  = r_note_div;
    assign pos_vol   = r_pos_vol;
    assign neg_vol   = r_neg_vol;
    assign src       = r_src;
    assign vol_level = r_vol;
    assign beat      = r_beat;

endmodule

// File: tb/tb_tone_scheduler.sv
// Scoreboard bench for tone_scheduler: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_tone_scheduler;

    localparam int unsigned BEAT_DIV = 4;
    localparam int unsigned ROM_AW   = 6;

    localparam bit [5:0] M_DIV  = 6'b000001;
    localparam bit [5:0] M_SRC  = 6'b000010;
    localparam bit [5:0] M_VOL  = 6'b000100;
    localparam bit [5:0] M_LVL  = 6'b001000;
    localparam bit [5:0] M_ADDR = 6'b010000;
    localparam bit [5:0] M_BEAT = 6'b100000;
    localparam bit [5:0] M_ALL  = 6'b111111;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              play_en = 1'b0;
    logic              key_valid = 1'b0;
    logic [21:0]       key_div = 22'd0;
    logic              vol_up = 1'b0;
    logic              vol_down = 1'b0;
    logic              mute = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [21:0]       rom_div = 22'd0;
    logic [3:0]        rom_len = 4'd0;
    logic [21:0]       note_div;
    logic [15:0]       pos_vol;
    logic [15:0]       neg_vol;
    logic [1:0]        src;
    logic [2:0]        vol_level;
    logic              beat;

    tone_scheduler #(.BEAT_DIV(BEAT_DIV), .ROM_AW(ROM_AW)) dut (
        .clk(clk), .rst(rst), .play_en(play_en), .key_valid(key_valid),
        .key_div(key_div), .vol_up(vol_up), .vol_down(vol_down), .mute(mute),
        .rom_addr(rom_addr), .rom_div(rom_div), .rom_len(rom_len),
        .note_div(note_div), .pos_vol(pos_vol), .neg_vol(neg_vol), .src(src),
        .vol_level(vol_level), .beat(beat)
    );

    always #5 clk = ~clk;

    // Melody ROM with one cycle of read latency: {100,2}, rest {0,1}, end marker.
    logic [21:0] rom_d [64];
    logic [3:0]  rom_l [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_d[i] = 22'd0;
            rom_l[i] = 4'd0;
        end
        rom_d[0] = 22'd100; rom_l[0] = 4'd2;
        rom_d[1] = 22'd0;   rom_l[1] = 4'd1;
    end
    always @(posedge clk) begin
        rom_div <= rom_d[rom_addr];
        rom_len <= rom_l[rom_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit [5:0]    mask;
        logic [21:0] div;
        logic [1:0]  src;
        logic [15:0] pv;
        logic [15:0] nv;
        logic [2:0]  lvl;
        logic [5:0]  addr;
        logic        beat;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input int dly, input string nm, input bit [5:0] m,
                       input logic [21:0] d, input logic [1:0] s,
                       input logic [15:0] p, input logic [15:0] n,
                       input logic [2:0] l, input logic [5:0] a, input logic b);
        exp_t e;
        e.cyc = cyc + dly; e.mask = m; e.div = d; e.src = s; e.pv = p; e.nv = n;
        e.lvl = l; e.addr = a; e.beat = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation whose cycle stamp has arrived.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t  e;
            string nm;
            bit    ok;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ok = (e.cyc == cyc);
            if (e.mask[0] && note_div  !== e.div)  ok = 1'b0;
            if (e.mask[1] && src       !== e.src)  ok = 1'b0;
            if (e.mask[2] && (pos_vol !== e.pv || neg_vol !== e.nv)) ok = 1'b0;
            if (e.mask[3] && vol_level !== e.lvl)  ok = 1'b0;
            if (e.mask[4] && rom_addr  !== e.addr) ok = 1'b0;
            if (e.mask[5] && beat      !== e.beat) ok = 1'b0;
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got div=%0d src=%b pos=%h neg=%h lvl=%0d addr=%0d beat=%b; need div=%0d src=%b pos=%h neg=%h lvl=%0d addr=%0d beat=%b (mask %b)",
                         nm, cyc, note_div, src, pos_vol, neg_vol, vol_level, rom_addr, beat,
                         e.div, e.src, e.pv, e.nv, e.lvl, e.addr, e.beat, e.mask);
            end
        end
    end

    initial begin
        step(2);
        chk(0, "reset", M_ALL, 22'd0, 2'b00, 16'h0000, 16'h0000, 3'd3, 6'd0, 1'b0);

        // Melody: 2-beat note, 1-beat rest, end marker wraps back to address 0.
        rst = 1'b0; play_en = 1'b1;
        chk(3,  "mel_pre",   M_SRC, 0, 2'b00, 0, 0, 0, 0, 0);
        chk(4,  "mel_on",    M_DIV | M_SRC | M_VOL, 22'd100, 2'b01, 16'h2000, 16'hE000, 0, 0, 0);
        chk(7,  "beat1",     M_BEAT, 0, 0, 0, 0, 0, 0, 1'b1);
        chk(8,  "beat_low",  M_BEAT, 0, 0, 0, 0, 0, 0, 1'b0);
        chk(11, "beat2",     M_BEAT | M_SRC | M_DIV | M_ADDR, 22'd100, 2'b01, 0, 0, 0, 6'd1, 1'b1);
        chk(13, "load_hold", M_DIV | M_SRC | M_VOL, 22'd100, 2'b01, 16'h2000, 16'hE000, 0, 0, 0);
        chk(14, "rest",      M_DIV | M_SRC | M_VOL, 22'd100, 2'b00, 16'h0000, 16'h0000, 0, 0, 0);
        chk(17, "rest_end",  M_BEAT | M_ADDR, 0, 0, 0, 0, 0, 6'd2, 1'b1);
        chk(19, "addr_wrap", M_ADDR, 0, 0, 0, 0, 0, 6'd0, 0);
        chk(22, "replay",    M_DIV | M_SRC | M_VOL, 22'd100, 2'b01, 16'h2000, 16'hE000, 0, 0, 0);
        step(23);

        // Key preemption with beat counter at 2.
        key_valid = 1'b1; key_div = 22'd500;
        chk(1, "key",     M_DIV | M_SRC | M_VOL, 22'd500, 2'b10, 16'h2000, 16'hE000, 0, 0, 0);
        chk(4, "key_frz", M_SRC | M_BEAT, 0, 2'b10, 0, 0, 0, 0, 1'b0);
        step(5);
        key_valid = 1'b0;
        chk(1, "resume",      M_DIV | M_SRC | M_BEAT, 22'd100, 2'b01, 0, 0, 0, 0, 1'b0);
        chk(2, "resume_beat", M_BEAT, 0, 0, 0, 0, 0, 0, 1'b1);
        chk(6, "note_end",    M_BEAT | M_ADDR, 0, 0, 0, 0, 0, 6'd1, 1'b1);
        step(6);
        step(12);

        // Pause at beat counter 2.
        chk(0, "pre_pause", M_DIV | M_SRC, 22'd100, 2'b01, 0, 0, 0, 0, 0);
        play_en = 1'b0;
        chk(1, "pause",      M_DIV | M_SRC | M_VOL, 22'd100, 2'b00, 16'h0000, 16'h0000, 0, 0, 0);
        chk(3, "pause_hold", M_SRC | M_BEAT, 0, 2'b00, 0, 0, 0, 0, 1'b0);
        step(3);
        play_en = 1'b1;
        chk(1, "unpause",      M_DIV | M_SRC | M_BEAT, 22'd100, 2'b01, 0, 0, 0, 0, 1'b0);
        chk(2, "unpause_beat", M_BEAT, 0, 0, 0, 0, 0, 0, 1'b1);
        step(2);

        // Volume saturation, held under a key so the source is non-silent.
        key_valid = 1'b1; key_div = 22'd300; vol_up = 1'b1;
        chk(1, "vu1",    M_DIV | M_SRC | M_VOL | M_LVL, 22'd300, 2'b10, 16'h2000, 16'hE000, 3'd4, 0, 0);
        chk(2, "vu2",    M_VOL | M_LVL, 0, 0, 16'h3000, 16'hD000, 3'd5, 0, 0);
        chk(4, "vu_sat", M_VOL | M_LVL, 0, 0, 16'h4000, 16'hC000, 3'd5, 0, 0);
        step(4);
        vol_up = 1'b0; vol_down = 1'b1;
        chk(3, "vd3",    M_VOL | M_LVL, 0, 0, 16'h2000, 16'hE000, 3'd2, 0, 0);
        chk(5, "vd5",    M_VOL | M_LVL, 0, 0, 16'h0800, 16'hF800, 3'd0, 0, 0);
        chk(6, "vd_sat", M_VOL | M_LVL, 0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0);
        step(6);
        vol_down = 1'b0; vol_up = 1'b1;
        step(1);
        chk(0, "vu_from0", M_LVL, 0, 0, 0, 0, 3'd1, 0, 0);
        vol_down = 1'b1;
        step(2);
        chk(0, "both", M_VOL | M_LVL, 0, 0, 16'h0800, 16'hF800, 3'd1, 0, 0);
        vol_down = 1'b0;
        step(2);
        chk(0, "vu_to3", M_VOL | M_LVL, 0, 0, 16'h1000, 16'hF000, 3'd3, 0, 0);
        vol_up = 1'b0; mute = 1'b1;
        step(1);
        chk(0, "mute", M_SRC | M_VOL | M_LVL, 0, 2'b10, 16'h0000, 16'h0000, 3'd3, 0, 0);
        mute = 1'b0;
        step(1);
        chk(0, "unmute", M_VOL, 0, 0, 16'h2000, 16'hE000, 0, 0, 0);

        // Nothing active: silent, divider held from the last key.
        key_valid = 1'b0; play_en = 1'b0;
        step(1);
        chk(0, "silent", M_DIV | M_SRC | M_VOL, 22'd300, 2'b00, 16'h0000, 16'h0000, 0, 0, 0);

        // Reset while the melody is running.
        play_en = 1'b1; vol_down = 1'b1;
        step(2);
        vol_down = 1'b0; rst = 1'b1;
        step(1);
        chk(0, "rst_mid", M_ALL, 22'd0, 2'b00, 16'h0000, 16'h0000, 3'd3, 6'd0, 1'b0);
        rst = 1'b0; play_en = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
